imem_boot_loader: RTL

//  Upstream stage of single_cycle_processor: receives a program as a byte stream, writes it into the

---
 rtl/boot_pkg.sv | 23 ++
 rtl/byte_word_packer.sv | 33 +++
 rtl/imem_boot_loader.sv | 128 ++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

  localparam int unsigned LEN_WIDTH  = 16;
  localparam logic [31:0] HALT_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    RUN,
    HALTED,
    ERROR
  } boot_state_t;

  // States in which the loader consumes stream bytes.
  function automatic logic accepts_bytes(input boot_state_t s);
    return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid flags the
// fourth byte, with the completed word presented combinationally alongside it.
module byte_word_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_idx;
  logic [23:0] low_q;

  assign word_valid = in_valid && (byte_idx == 2'd3);
  assign word       = {in_byte, low_q};

  // Earlier bytes enter at the top and drift down, so byte 0 ends in [7:0].
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      byte_idx <= '0;
      low_q    <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      low_q    <= '0;
    end else if (in_valid) begin
      byte_idx <= byte_idx + 2'd1;
      low_q    <= {in_byte, low_q[23:8]};
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream program loader for single_cycle_processor: fills instruction memory,
// releases the core, detects halt. Optional trailing checksum byte: BOOT_CHECKSUM_EN.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned CYCLE_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [31:0]            imem_wdata,
  input  logic [31:0]            fetch_instr,
  output logic                   core_reset,
  output logic                   busy,
  output logic                   halted,
  output logic                   error,
  output logic [CYCLE_WIDTH-1:0] run_cycles
);

  localparam int unsigned MAX_WORDS = 1 << ADDR_WIDTH;

  boot_state_t state_q, state_d;

  logic [7:0]            len_lo_q;
  logic [LEN_WIDTH-1:0]  len_full;
  logic                  len_ok;
  logic [ADDR_WIDTH-1:0] last_idx_q;
  logic [ADDR_WIDTH-1:0] word_idx_q;
  logic                  xfer;
  logic                  start_ok;
  logic                  halt_seen;
  logic                  last_word;
  logic                  word_valid;
  logic [31:0]           word;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  assign xfer      = rx_valid && rx_ready;
  assign start_ok  = start && ((state_q == IDLE) || (state_q == HALTED) || (state_q == ERROR));
  assign len_full  = {rx_data, len_lo_q};
  assign len_ok    = (len_full != '0) && (32'(len_full) <= MAX_WORDS);
  assign halt_seen = (state_q == RUN) && !core_reset && (fetch_instr == HALT_INSTR);
  assign last_word = word_valid && (word_idx_q == last_idx_q);

  byte_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (state_q != DATA),
    .in_valid   (xfer && (state_q == DATA)),
    .in_byte    (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALTED, ERROR: if (start_ok) state_d = LEN_LO;
      LEN_LO:              if (xfer) state_d = LEN_HI;
      LEN_HI:              if (xfer) state_d = len_ok ? DATA : ERROR;
`ifdef BOOT_CHECKSUM_EN
      DATA:                if (last_word) state_d = CHECK;
      CHECK:               if (xfer) state_d = (rx_data == csum_q) ? RUN : ERROR;
`else
      DATA:                if (last_word) state_d = RUN;
`endif
      RUN:                 if (halt_seen) state_d = HALTED;
      default:             state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rx_ready   <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      error      <= 1'b0;
      core_reset <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      run_cycles <= '0;
      len_lo_q   <= '0;
      last_idx_q <= '0;
      word_idx_q <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rx_ready <= accepts_bytes(state_d);
      busy     <= accepts_bytes(state_d);
      halted   <= (state_d == HALTED);
      error    <= (state_d == ERROR);
      // Held in reset on the RUN entry cycle, released only while RUN persists.
      core_reset <= !((state_q == RUN) && (state_d == RUN));
      imem_we    <= word_valid;
      if (word_valid) begin
        imem_addr  <= word_idx_q;
        imem_wdata <= word;
        word_idx_q <= word_idx_q + ADDR_WIDTH'(1);
      end
      if ((state_q == LEN_LO) && xfer) len_lo_q <= rx_data;
      if ((state_q == LEN_HI) && xfer) begin
        last_idx_q <= ADDR_WIDTH'(len_full - LEN_WIDTH'(1));
        word_idx_q <= '0;
      end
`ifdef BOOT_CHECKSUM_EN
      if ((state_q == LEN_HI) && xfer)    csum_q <= '0;
      else if ((state_q == DATA) && xfer) csum_q <= csum_q + rx_data;
`endif
      if (start_ok)
        run_cycles <= '0;
      else if ((state_q == RUN) && !core_reset && (run_cycles != '1))
        run_cycles <= run_cycles + CYCLE_WIDTH'(1);
    end
  end

endmodule
